mac_array_layer_ctrl: RTL and testbench

Layer-level sequencer for mac_array. It accepts one layer configuration, splits the input channels into tiles of ARRAY_NUM channels, and runs each tile in two steps:
- asks the weight BIU to stream that tile's weights into the array;
- pulses conv_start and waits for conv_done.
It drives the per-tile in_ch, out_ch and map_size to mac_array, and first/last-tile flags to psum_acc (accumulate vs. initialise).

---
 rtl/mac_array_layer_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_mac_array_layer_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_layer_ctrl.sv
// Layer sequencer for mac_array: splits a layer into ARRAY_NUM-channel tiles, loads weights, runs convs.
// Optional watchdog on the BIU/array waits is enabled by defining MAC_LAYER_CTRL_WDOG_EN.
module mac_array_layer_ctrl #(
  parameter int unsigned ARRAY_NUM      = 32,
  parameter int unsigned W_BYTES_PER_CH = 10,
  parameter int unsigned WDOG_CYC       = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_vld,
  output logic        cfg_rdy,
  input  logic [7:0]  cfg_in_ch,
  input  logic [7:0]  cfg_out_ch,
  input  logic [15:0] cfg_map_size,
  input  logic [31:0] cfg_wbase,
  output logic        wld_req,
  input  logic        wld_gnt,
  output logic [31:0] wld_addr,
  output logic [15:0] wld_len,
  input  logic        wld_done,
  output logic        conv_start,
  input  logic        conv_done,
  output logic [7:0]  in_ch,
  output logic [7:0]  out_ch,
  output logic [15:0] map_size,
  output logic        tile_first,
  output logic        tile_last,
  output logic        busy,
  output logic        layer_done,
  output logic        err
);

  localparam int unsigned LEN_PER_OCH = ARRAY_NUM * W_BYTES_PER_CH / 4;
  localparam logic [7:0]  TILE_CH     = 8'(ARRAY_NUM);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_LOAD = 3'd2,
    S_CONV      = 3'd3,
    S_WAIT_CONV = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t      state_r;
  logic        cfg_rdy_r;
  logic        wld_req_r;
  logic [31:0] wld_addr_r;
  logic [15:0] wld_len_r;
  logic        conv_start_r;
  logic [7:0]  in_ch_r;
  logic [7:0]  out_ch_r;
  logic [15:0] map_size_r;
  logic        tile_first_r;
  logic        tile_last_r;
  logic        busy_r;
  logic        layer_done_r;
  logic        err_r;
  logic [7:0]  n_tiles_r;
  logic [7:0]  tile_idx_r;
  logic [7:0]  rem_ch_r;

  logic        cfg_zero_s;
  logic [8:0]  cfg_tiles_s;
  logic [7:0]  cfg_first_ch_s;
  logic [15:0] cfg_len_s;
  logic [7:0]  rem_next_s;
  logic [7:0]  next_ch_s;
  logic [7:0]  tile_next_s;
  logic [31:0] stride_s;

  // Config decode and next-tile arithmetic
  always_comb begin
    cfg_zero_s  = (cfg_in_ch == 8'd0) || (cfg_out_ch == 8'd0) || (cfg_map_size == 16'd0);
    cfg_tiles_s = (9'(cfg_in_ch) + 9'(ARRAY_NUM - 1)) / 9'(ARRAY_NUM);
    cfg_len_s   = 16'({8'd0, cfg_out_ch} * 16'(LEN_PER_OCH));
    if (cfg_in_ch > TILE_CH) begin
      cfg_first_ch_s = TILE_CH;
    end else begin
      cfg_first_ch_s = cfg_in_ch;
    end
    rem_next_s = rem_ch_r - TILE_CH;
    if (rem_next_s > TILE_CH) begin
      next_ch_s = TILE_CH;
    end else begin
      next_ch_s = rem_next_s;
    end
    tile_next_s = tile_idx_r + 8'd1;
    stride_s    = {14'd0, wld_len_r, 2'b00};
  end

`ifdef MAC_LAYER_CTRL_WDOG_EN
  localparam logic [23:0] WDOG_LAST = 24'(WDOG_CYC - 2);

  logic [23:0] wdog_cnt_r;
  logic        wdog_hit_s;

  // Cycles spent in a wait state; zero on entry so the limit is measured per wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_r <= 24'd0;
    end else if ((state_r == S_WAIT_LOAD) || (state_r == S_WAIT_CONV)) begin
      wdog_cnt_r <= wdog_cnt_r + 24'd1;
    end else begin
      wdog_cnt_r <= 24'd0;
    end
  end

  // The transition fires on the edge at which the count reaches WDOG_CYC-1
  assign wdog_hit_s = (wdog_cnt_r == WDOG_LAST);
`endif

  // Layer FSM with tile bookkeeping and every output registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      cfg_rdy_r    <= 1'b1;
      wld_req_r    <= 1'b0;
      wld_addr_r   <= 32'd0;
      wld_len_r    <= 16'd0;
      conv_start_r <= 1'b0;
      in_ch_r      <= 8'd0;
      out_ch_r     <= 8'd0;
      map_size_r   <= 16'd0;
      tile_first_r <= 1'b0;
      tile_last_r  <= 1'b0;
      busy_r       <= 1'b0;
      layer_done_r <= 1'b0;
      err_r        <= 1'b0;
      n_tiles_r    <= 8'd0;
      tile_idx_r   <= 8'd0;
      rem_ch_r     <= 8'd0;
    end else begin
      conv_start_r <= 1'b0;
      layer_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (cfg_vld && cfg_rdy_r) begin
            out_ch_r     <= cfg_out_ch;
            map_size_r   <= cfg_map_size;
            wld_addr_r   <= cfg_wbase;
            wld_len_r    <= cfg_len_s;
            rem_ch_r     <= cfg_in_ch;
            in_ch_r      <= cfg_first_ch_s;
            n_tiles_r    <= cfg_tiles_s[7:0];
            tile_idx_r   <= 8'd0;
            tile_first_r <= 1'b1;
            tile_last_r  <= (cfg_tiles_s == 9'd1);
            cfg_rdy_r    <= 1'b0;
            busy_r       <= 1'b1;
            if (cfg_zero_s) begin
              err_r   <= 1'b1;
              state_r <= S_DONE;
            end else begin
              err_r     <= 1'b0;
              wld_req_r <= 1'b1;
              state_r   <= S_LOAD;
            end
          end
        end
        // A wld_done alongside the grant is dropped; the BIU re-pulses it later
        S_LOAD: begin
          if (wld_gnt) begin
            wld_req_r <= 1'b0;
            state_r   <= S_WAIT_LOAD;
          end
        end
        S_WAIT_LOAD: begin
          if (wld_done) begin
            conv_start_r <= 1'b1;
            state_r      <= S_CONV;
          end
`ifdef MAC_LAYER_CTRL_WDOG_EN
          else if (wdog_hit_s) begin
            err_r   <= 1'b1;
            state_r <= S_DONE;
          end
`endif
        end
        S_CONV: begin
          state_r <= S_WAIT_CONV;
        end
        S_WAIT_CONV: begin
          if (conv_done) begin
            if (tile_last_r) begin
              state_r <= S_DONE;
            end else begin
              tile_idx_r   <= tile_next_s;
              wld_addr_r   <= wld_addr_r + stride_s;
              rem_ch_r     <= rem_next_s;
              in_ch_r      <= next_ch_s;
              tile_first_r <= 1'b0;
              tile_last_r  <= (tile_next_s == (n_tiles_r - 8'd1));
              wld_req_r    <= 1'b1;
              state_r      <= S_LOAD;
            end
          end
`ifdef MAC_LAYER_CTRL_WDOG_EN
          else if (wdog_hit_s) begin
            err_r   <= 1'b1;
            state_r <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          layer_done_r <= 1'b1;
          busy_r       <= 1'b0;
          cfg_rdy_r    <= 1'b1;
          state_r      <= S_IDLE;
        end
        default: begin
          wld_req_r <= 1'b0;
          busy_r    <= 1'b0;
          cfg_rdy_r <= 1'b1;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg_rdy    = cfg_rdy_r;
  assign wld_req    = wld_req_r;
  assign wld_addr   = wld_addr_r;
  assign wld_len    = wld_len_r;
  assign conv_start = conv_start_r;
  assign in_ch      = in_ch_r;
  assign out_ch     = out_ch_r;
  assign map_size   = map_size_r;
  assign tile_first = tile_first_r;
  assign tile_last  = tile_last_r;
  assign busy       = busy_r;
  assign layer_done = layer_done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_mac_array_layer_ctrl.sv
// Scoreboard bench for mac_array_layer_ctrl: a tile-level model fills expectation queues,
// responder processes play BIU and mac_array, and a monitor pops and compares on DUT events.
module tb_mac_array_layer_ctrl;

  localparam int ARRAY_NUM = 32;
  localparam int W_BYTES   = 10;
  localparam int WDOG      = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_vld = 1'b0;
  logic        cfg_rdy;
  logic [7:0]  cfg_in_ch = 8'd0;
  logic [7:0]  cfg_out_ch = 8'd0;
  logic [15:0] cfg_map_size = 16'd0;
  logic [31:0] cfg_wbase = 32'd0;
  logic        wld_req;
  logic        wld_gnt = 1'b0;
  logic [31:0] wld_addr;
  logic [15:0] wld_len;
  logic        wld_done;
  logic        conv_start;
  logic        conv_done;
  logic [7:0]  in_ch;
  logic [7:0]  out_ch;
  logic [15:0] map_size;
  logic        tile_first;
  logic        tile_last;
  logic        busy;
  logic        layer_done;
  logic        err;

  logic biu_done = 1'b0;
  logic wld_done_inj = 1'b0;
  logic mac_done = 1'b0;
  logic conv_done_inj = 1'b0;
  logic conv_en = 1'b1;

  assign wld_done  = biu_done | wld_done_inj;
  assign conv_done = mac_done | conv_done_inj;

  always #5 clk = ~clk;

  mac_array_layer_ctrl #(
    .ARRAY_NUM(ARRAY_NUM), .W_BYTES_PER_CH(W_BYTES), .WDOG_CYC(WDOG)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
    .cfg_map_size(cfg_map_size), .cfg_wbase(cfg_wbase),
    .wld_req(wld_req), .wld_gnt(wld_gnt), .wld_addr(wld_addr), .wld_len(wld_len),
    .wld_done(wld_done), .conv_start(conv_start), .conv_done(conv_done),
    .in_ch(in_ch), .out_ch(out_ch), .map_size(map_size),
    .tile_first(tile_first), .tile_last(tile_last),
    .busy(busy), .layer_done(layer_done), .err(err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
    logic [7:0]  ich;
    logic [7:0]  och;
    logic [15:0] map;
    logic        first;
    logic        last;
  } tile_t;

  tile_t load_q[$];
  tile_t conv_q[$];
  bit    done_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected tiles of one layer computed directly from the channel count
  task automatic push_layer(input logic [7:0] i, input logic [7:0] o, input logic [15:0] m,
                            input logic [31:0] b, input int max_tiles, input bit push_done);
    int    nt;
    int    rem;
    tile_t t;
    if (i == 8'd0 || o == 8'd0 || m == 16'd0) begin
      if (push_done) done_q.push_back(1'b1);
      return;
    end
    nt = (int'(i) + ARRAY_NUM - 1) / ARRAY_NUM;
    for (int k = 0; k < nt && k < max_tiles; k++) begin
      rem     = int'(i) - k * ARRAY_NUM;
      t.ich   = 8'((rem < ARRAY_NUM) ? rem : ARRAY_NUM);
      t.len   = 16'(int'(o) * ARRAY_NUM * W_BYTES / 4);
      t.addr  = b + 32'(k * int'(t.len) * 4);
      t.och   = o;
      t.map   = m;
      t.first = (k == 0);
      t.last  = (k == nt - 1);
      load_q.push_back(t);
      conv_q.push_back(t);
    end
    if (push_done) done_q.push_back(max_tiles < nt);
  endtask

  // BIU: grant after a random delay (sometimes with a stray done), then a real done
  initial begin
    forever begin
      @(negedge clk);
      wld_gnt  = 1'b0;
      biu_done = 1'b0;
      if (wld_req && !rst) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        wld_gnt = 1'b1;
        if ($urandom_range(0, 3) == 0) biu_done = 1'b1;
        @(negedge clk);
        wld_gnt  = 1'b0;
        biu_done = 1'b0;
        repeat ($urandom_range(0, 5)) @(negedge clk);
        biu_done = 1'b1;
        @(negedge clk);
        biu_done = 1'b0;
      end
    end
  end

  // mac_array: optional done coincident with conv_start (must be ignored), then real done
  initial begin
    forever begin
      @(negedge clk);
      mac_done = 1'b0;
      if (conv_start && conv_en && !rst) begin
        if ($urandom_range(0, 2) == 0) begin
          mac_done = 1'b1;
          @(negedge clk);
          mac_done = 1'b0;
        end
        repeat ($urandom_range(1, 6)) @(negedge clk);
        mac_done = 1'b1;
        @(negedge clk);
        mac_done = 1'b0;
      end
    end
  end

  // Stray done pulses in states where they must be ignored
  initial begin
    forever begin
      @(negedge clk);
      conv_done_inj = 1'b0;
      wld_done_inj  = 1'b0;
      if (!rst) begin
        if (wld_req && $urandom_range(0, 3) == 0) conv_done_inj = 1'b1;
        if (conv_start && $urandom_range(0, 1) == 0) wld_done_inj = 1'b1;
      end
    end
  end

  tile_t exp_t;
  tile_t last_load;
  logic  prev_req = 1'b0;
  logic  prev_cs = 1'b0;
  logic  prev_gnt = 1'b0;
  bit    exp_err;

  // Monitor: pop expectations whenever the DUT presents an event
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("cfg_rdy_vs_busy", 96'(cfg_rdy), 96'(!busy));
        if (prev_gnt) chk("wld_req_drop_after_gnt", 96'(wld_req), 96'(0));
        if (wld_req && !prev_req) begin
          chk("load_q_has_entry", 96'(load_q.size() != 0), 96'(1));
          if (load_q.size() != 0) begin
            exp_t     = load_q.pop_front();
            last_load = exp_t;
            chk("wld_addr", 96'(wld_addr), 96'(exp_t.addr));
            chk("wld_len", 96'(wld_len), 96'(exp_t.len));
            chk("load_in_ch", 96'(in_ch), 96'(exp_t.ich));
            chk("load_first_last", 96'({tile_first, tile_last}), 96'({exp_t.first, exp_t.last}));
          end
        end
        if (wld_req && wld_gnt) begin
          chk("wld_addr_at_gnt", 96'(wld_addr), 96'(last_load.addr));
          chk("wld_len_at_gnt", 96'(wld_len), 96'(last_load.len));
        end
        if (conv_start) begin
          chk("conv_start_one_cycle", 96'(prev_cs), 96'(0));
          chk("conv_q_has_entry", 96'(conv_q.size() != 0), 96'(1));
          if (conv_q.size() != 0) begin
            exp_t = conv_q.pop_front();
            chk("conv_in_ch", 96'(in_ch), 96'(exp_t.ich));
            chk("conv_out_ch", 96'(out_ch), 96'(exp_t.och));
            chk("conv_map_size", 96'(map_size), 96'(exp_t.map));
            chk("conv_first_last", 96'({tile_first, tile_last}), 96'({exp_t.first, exp_t.last}));
          end
        end
        if (layer_done) begin
          chk("done_q_has_entry", 96'(done_q.size() != 0), 96'(1));
          if (done_q.size() != 0) begin
            exp_err = done_q.pop_front();
            chk("layer_err", 96'(err), 96'(exp_err));
          end
        end
      end
      prev_req = wld_req && !rst;
      prev_cs  = conv_start && !rst;
      prev_gnt = wld_req && wld_gnt && !rst;
    end
  end

  task automatic chk_reset(input string name);
    chk(name, 96'({cfg_rdy, wld_req, wld_addr, wld_len, conv_start, in_ch, out_ch, map_size,
                   tile_first, tile_last, busy, layer_done, err}), 96'({1'b1, 87'd0}));
  endtask

  task automatic issue(input logic [7:0] i, input logic [7:0] o, input logic [15:0] m,
                       input logic [31:0] b, input int max_tiles, input bit push_done);
    chk("cfg_rdy_before_cfg", 96'(cfg_rdy), 96'(1));
    push_layer(i, o, m, b, max_tiles, push_done);
    cfg_in_ch    = i;
    cfg_out_ch   = o;
    cfg_map_size = m;
    cfg_wbase    = b;
    cfg_vld      = 1'b1;
    @(negedge clk);
    cfg_vld = 1'b0;
    chk("busy_after_accept", 96'(busy), 96'(1));
    chk("err_after_accept", 96'(err), 96'(i == 8'd0 || o == 8'd0 || m == 16'd0));
  endtask

  // Wait for layer_done, throwing ignored cfg_vld pulses at the busy DUT
  task automatic run_until_done(input int bound);
    bit got;
    got = 1'b0;
    for (int c = 0; c < bound && !got; c++) begin
      @(negedge clk);
      if (layer_done) begin
        got     = 1'b1;
        cfg_vld = 1'b0;
      end else if (busy && $urandom_range(0, 3) == 0) begin
        cfg_vld      = 1'b1;
        cfg_in_ch    = 8'($urandom);
        cfg_out_ch   = 8'($urandom);
        cfg_map_size = 16'($urandom);
        cfg_wbase    = $urandom;
      end else begin
        cfg_vld = 1'b0;
      end
    end
    cfg_vld = 1'b0;
    chk("layer_done_within_bound", 96'(got), 96'(1));
  endtask

  task automatic wait_conv_start();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      if (conv_start) seen = 1'b1;
    end
    chk("conv_start_within_bound", 96'(seen), 96'(1));
  endtask

  initial begin
    bit got;
    int lat;
    repeat (3) @(negedge clk);
    chk_reset("reset_state");
    rst = 1'b0;
    @(negedge clk);

    issue(8'd64, 8'd4, 16'd16, 32'h0000_1000, 8, 1'b1);
    run_until_done(2000);
    issue(8'd40, 8'd1, 16'd49, 32'h0000_2000, 8, 1'b1);
    run_until_done(2000);
    issue(8'd255, 8'd255, 16'd3, 32'hFFFF_0000, 8, 1'b1);
    run_until_done(4000);

    issue(8'd0, 8'd3, 16'd9, 32'h0000_0040, 8, 1'b1);
    chk("zero_no_done_yet", 96'(layer_done), 96'(0));
    @(negedge clk);
    chk("zero_done_two_cycles", 96'(layer_done), 96'(1));
    chk("zero_err", 96'(err), 96'(1));
    issue(8'd5, 8'd2, 16'd4, 32'h0000_0100, 8, 1'b1);
    run_until_done(2000);

    for (int n = 0; n < 20; n++) begin
      logic [7:0]  ri;
      logic [7:0]  ro;
      logic [15:0] rm;
      ri = 8'($urandom_range(1, 255));
      ro = 8'($urandom_range(1, 40));
      rm = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ri = 8'd0;
      if ($urandom_range(0, 9) == 0) ro = 8'd0;
      issue(ri, ro, rm, $urandom, 8, 1'b1);
      run_until_done(4000);
    end

    conv_en = 1'b0;
`ifdef MAC_LAYER_CTRL_WDOG_EN
    issue(8'd64, 8'd2, 16'd100, 32'h0000_4000, 1, 1'b1);
    wait_conv_start();
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      if (layer_done) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk("wdog_done_latency", 96'(lat), 96'(WDOG + 1));
    chk("wdog_err", 96'(err), 96'(1));
    issue(8'd64, 8'd2, 16'd100, 32'h0000_4000, 1, 1'b0);
    wait_conv_start();
    repeat (3) @(negedge clk);
`else
    issue(8'd64, 8'd2, 16'd100, 32'h0000_4000, 1, 1'b0);
    wait_conv_start();
    got = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (layer_done) got = 1'b1;
    end
    chk("no_wdog_no_done", 96'(got), 96'(0));
    chk("no_wdog_still_busy", 96'(busy), 96'(1));
`endif

    rst = 1'b1;
    load_q.delete();
    conv_q.delete();
    done_q.delete();
    @(negedge clk);
    chk_reset("reset_mid_layer");
    rst     = 1'b0;
    conv_en = 1'b1;
    @(negedge clk);
    issue(8'd33, 8'd3, 16'd7, 32'h0000_8000, 8, 1'b1);
    run_until_done(3000);

    repeat (5) @(negedge clk);
    chk("load_q_drained", 96'(load_q.size()), 96'(0));
    chk("conv_q_drained", 96'(conv_q.size()), 96'(0));
    chk("done_q_drained", 96'(done_q.size()), 96'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
